store_align_unit: RTL
=====================

Name: store_align_unit

Overview:
- Store-side counterpart to the load-path sign extender: narrows a 32-bit register value to byte/halfword/word, replicates it onto the correct byte lanes, and generates byte enables.
- Runs the data-memory write handshake (req/ack) and stalls the MEM stage until the write completes or times out.
- Sits between the EX/MEM pipeline register and the data memory write port.

Parameters:
TIMEOUT, 16, max cycles in REQ without mem_ack before abort (>=2)
CNT_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
st_valid  in  1  MEM stage holds a store this cycle
st_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
st_addr  in  32  byte address
st_data  in  32  register rt value; low bits significant for byte/half
st_ready  out  1  combinational; 1 only in IDLE
stall  out  1  combinational; hold MEM stage
st_exc  out  1  combinational; misaligned/illegal store this cycle
err_timeout  out  1  combinational; 1 in the cycle a REQ times out
mem_req  out  1  registered write request
mem_addr  out  32  registered; {st_addr[31:2],2'b00}
mem_wdata  out  32  registered lane-replicated data
mem_be  out  4  registered byte enables, lane i = bits 8i+7:8i
mem_ack  in  1  memory accepted write (sampled on clk)

Behaviour:
- Reset (sync, any state): state=IDLE, counter=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0; mid-REQ reset drops mem_req at that edge, write abandoned.
- States: IDLE, REQ.
- Legal check (combinational, IDLE only): byte always legal; half needs addr[0]=0; word needs addr[1:0]=00; size 11 illegal.
- IDLE, st_valid=1, illegal: st_exc=1, stall=0, no memory access, stay IDLE.
- IDLE, st_valid=1, legal: stall=1; next edge -> REQ, mem_req=1, register addr/data/be, counter=0.
- Byte: wdata={4{data[7:0]}}, be=0001<<addr[1:0].
- Half: wdata={2{data[15:0]}}, be = addr[1] ? 1100 : 0011.
- Word: wdata=data, be=1111.
- REQ: mem_req, mem_addr, mem_wdata, mem_be held stable until exit.
- REQ, mem_ack=1: stall=0 this cycle (pipeline advances); next edge -> IDLE, mem_req=0.
- REQ, no ack: counter++; stall=1.
- Timeout: when counter==TIMEOUT-1 and no ack, err_timeout=1 and stall=0 that cycle; next edge -> IDLE, mem_req=0.
- Ack and timeout in same cycle: ack wins, err_timeout=0.
- Write latency: one request cycle minimum (accept cycle + >=1 REQ cycle); back-to-back stores have one IDLE cycle between mem_req pulses.
- st_valid ignored outside IDLE (MEM stage is held by stall).
- mem_ack in IDLE ignored.

Test Plan:
- SB addr=0x1003 data=0xAABBCC5A, ack after 2 REQ cycles -> mem_addr=0x1000, wdata=0x5A5A5A5A, be=1000, stall high 2 cycles then low on the ack cycle.
- SH addr=0x2002 data=0x1234BEEF, immediate ack -> wdata=0xBEEFBEEF, be=1100, mem_req high exactly 1 cycle; SW addr=0x2004 -> be=1111, wdata=data.
- SH addr=0x2001, and SW addr=0x2006, and size=11 -> st_exc=1 same cycle, stall=0, mem_req never asserts.
- SW with mem_ack held 0, TIMEOUT=16 -> err_timeout=1 on the 16th REQ cycle, mem_req falls next edge, st_ready=1 after.
- Ack coinciding with the timeout cycle -> err_timeout=0, normal completion.
- Reset asserted during REQ -> next edge mem_req=0, be=0, state IDLE; new store accepted normally afterward.

Source files
------------

// File: rtl/store_align_unit.sv
// Store-path aligner: narrows and lane-replicates register data, builds byte enables,
// and runs the req/ack write handshake with a timeout, stalling MEM until done.
//
// state | meaning
// IDLE  | ready for a store; legality checked combinationally
// REQ   | write request outstanding, waiting for mem_ack or timeout
module store_align_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        stall,
    output logic        st_exc,
    output logic        err_timeout,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;

    logic        legal;
    logic        timeout_hit;
    logic [31:0] wdata_aligned;
    logic [3:0]  be_aligned;

    always_comb begin
        legal         = 1'b0;
        wdata_aligned = st_data;
        be_aligned    = 4'b1111;
        case (st_size)
            2'b00: begin
                legal         = 1'b1;
                wdata_aligned = {4{st_data[7:0]}};
                be_aligned    = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                legal         = ~st_addr[0];
                wdata_aligned = {2{st_data[15:0]}};
                be_aligned    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                legal         = (st_addr[1:0] == 2'b00);
                wdata_aligned = st_data;
                be_aligned    = 4'b1111;
            end
            default: begin
                legal         = 1'b0;
                wdata_aligned = st_data;
                be_aligned    = 4'b1111;
            end
        endcase
    end

    // Ack takes priority over the timeout when both land in the same cycle.
    assign timeout_hit = (state_q == S_REQ) && !mem_ack
                         && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        st_ready    = 1'b0;
        stall       = 1'b0;
        st_exc      = 1'b0;
        err_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                st_ready = 1'b1;
                if (st_valid) begin
                    if (legal) begin
                        stall       = 1'b1;
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {st_addr[31:2], 2'b00};
                        mem_wdata_d = wdata_aligned;
                        mem_be_d    = be_aligned;
                    end else begin
                        st_exc = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end else if (timeout_hit) begin
                    err_timeout = 1'b1;
                    state_d     = S_IDLE;
                    mem_req_d   = 1'b0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule
